// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: forwarding source codes,
// controller state encodings and register-index width.
package hazard_ctrl_pkg;

  localparam int REG_IDX_WIDTH = 5;

  localparam logic [1:0] FWD_SRC_REG = 2'b00;
  localparam logic [1:0] FWD_SRC_MEM = 2'b10;
  localparam logic [1:0] FWD_SRC_WB  = 2'b01;

  localparam logic [1:0] HZ_ST_RUN      = 2'b00;
  localparam logic [1:0] HZ_ST_MEM_WAIT = 2'b01;
  localparam logic [1:0] HZ_ST_FAULT    = 2'b10;

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// Operand forwarding selects for the two ALU inputs in EX.
// The youngest producer (EX/MEM) wins over the older one (MEM/WB).
module forward_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_IDX_WIDTH-1:0] ex_rs1,
  input  logic [REG_IDX_WIDTH-1:0] ex_rs2,
  input  logic [REG_IDX_WIDTH-1:0] mem_rd,
  input  logic                     mem_regWrite,
  input  logic [REG_IDX_WIDTH-1:0] wb_rd,
  input  logic                     wb_regWrite,
  output logic [1:0]               fwdA,
  output logic [1:0]               fwdB
);

  function automatic logic [1:0] pick_src(input logic [REG_IDX_WIDTH-1:0] rs);
    logic [1:0] src;
    src = FWD_SRC_REG;
    if (mem_regWrite && (mem_rd != '0) && (mem_rd == rs)) begin
      src = FWD_SRC_MEM;
    end else if (wb_regWrite && (wb_rd != '0) && (wb_rd == rs)) begin
      src = FWD_SRC_WB;
    end
    return src;
  endfunction

  always_comb begin
    fwdA = pick_src(ex_rs1);
    fwdB = pick_src(ex_rs2);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stalls, flushes, forwarding selects,
// data-memory wait tracking with timeout fault, and a stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REG_IDX_WIDTH-1:0] id_rs1,
  input  logic [REG_IDX_WIDTH-1:0] id_rs2,
  input  logic                     id_useRs1,
  input  logic                     id_useRs2,
  input  logic [REG_IDX_WIDTH-1:0] ex_rd,
  input  logic                     ex_memRead,
  input  logic                     ex_regWrite,
  input  logic                     ex_redirect,
  input  logic [REG_IDX_WIDTH-1:0] ex_rs1,
  input  logic [REG_IDX_WIDTH-1:0] ex_rs2,
  input  logic [REG_IDX_WIDTH-1:0] mem_rd,
  input  logic                     mem_regWrite,
  input  logic                     mem_req,
  input  logic                     dmem_ready,
  input  logic [REG_IDX_WIDTH-1:0] wb_rd,
  input  logic                     wb_regWrite,
  output logic                     pc_en,
  output logic                     ifid_en,
  output logic                     idex_en,
  output logic                     exmem_en,
  output logic                     ifid_flush,
  output logic                     idex_flush,
  output logic                     memwb_flush,
  output logic [1:0]               fwdA,
  output logic [1:0]               fwdB,
  output logic                     fault,
  output logic [CNT_W-1:0]         stall_cycles
);

  localparam logic [4:0] TIMEOUT_CNT = 5'(MEM_TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic [4:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic [1:0] fwd_a_raw, fwd_b_raw;
  logic       mem_stall, load_use, mem_done, ex_writes_unused;

  forward_unit u_forward_unit (
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .mem_rd       (mem_rd),
    .mem_regWrite (mem_regWrite),
    .wb_rd        (wb_rd),
    .wb_regWrite  (wb_regWrite),
    .fwdA         (fwd_a_raw),
    .fwdB         (fwd_b_raw)
  );

  // A load always writes a register, so ex_regWrite does not qualify load-use.
  assign ex_writes_unused = ex_regWrite;

  always_comb begin
    mem_done  = mem_req && dmem_ready;
    mem_stall = (mem_req && !dmem_ready) || (state_q == HZ_ST_FAULT);
    load_use  = ex_memRead && (ex_rd != '0) &&
                ((id_useRs1 && (id_rs1 == ex_rd)) || (id_useRs2 && (id_rs2 == ex_rd)));
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      HZ_ST_RUN: begin
        if (mem_stall) begin
          state_d    = HZ_ST_MEM_WAIT;
          wait_cnt_d = 5'd1;
        end
      end
      HZ_ST_MEM_WAIT: begin
        if (mem_done) begin
          state_d    = HZ_ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == TIMEOUT_CNT) begin
          state_d = HZ_ST_FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + 5'd1;
        end
      end
      HZ_ST_FAULT: begin
        state_d = HZ_ST_FAULT;
      end
      default: begin
        state_d    = HZ_ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Sequencing priority: reset > memory stall/fault > redirect > load-use > run.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    fwdA        = fwd_a_raw;
    fwdB        = fwd_b_raw;
    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
      fwdA        = FWD_SRC_REG;
      fwdB        = FWD_SRC_REG;
    end else if (mem_stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!pc_en) begin
      stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= HZ_ST_RUN;
      wait_cnt_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign fault        = (state_q == HZ_ST_FAULT);
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a reference model.
module tb_hazard_ctrl;

  localparam int T  = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic       id_useRs1, id_useRs2, ex_memRead, ex_regWrite, ex_redirect;
  logic       mem_regWrite, mem_req, dmem_ready, wb_regWrite;
  logic       pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush, fault;
  logic [1:0] fwdA, fwdB;
  logic [CW-1:0] stall_cycles;

  hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_useRs1(id_useRs1), .id_useRs2(id_useRs2),
    .ex_rd(ex_rd), .ex_memRead(ex_memRead), .ex_regWrite(ex_regWrite),
    .ex_redirect(ex_redirect), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .mem_rd(mem_rd), .mem_regWrite(mem_regWrite), .mem_req(mem_req),
    .dmem_ready(dmem_ready), .wb_rd(wb_rd), .wb_regWrite(wb_regWrite),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
    .fwdA(fwdA), .fwdB(fwdB), .fault(fault), .stall_cycles(stall_cycles)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: an access that keeps missing is counted in stall cycles;
  // once it has stalled T+1 cycles without completing, the core is faulted for good.
  bit chk_en    = 1'b0;
  bit m_faulted = 1'b0;
  bit m_busy    = 1'b0;
  int m_len     = 0;
  int m_stalls  = 0;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (mem_regWrite && mem_rd != 0 && mem_rd == rs) return 2'b10;
    if (wb_regWrite && wb_rd != 0 && wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  always @(negedge clk) begin
    logic [3:0] e_en;
    logic [2:0] e_fl;
    logic [1:0] e_a, e_b;
    bit stall, lu;
    if (chk_en) begin
      stall = m_faulted || (mem_req && !dmem_ready);
      lu = ex_memRead && ex_rd != 0 &&
           ((id_useRs1 && id_rs1 == ex_rd) || (id_useRs2 && id_rs2 == ex_rd));
      e_a = ref_fwd(ex_rs1);
      e_b = ref_fwd(ex_rs2);
      if (rst)              begin e_en = 4'b0000; e_fl = 3'b111; e_a = 0; e_b = 0; end
      else if (stall)       begin e_en = 4'b0000; e_fl = 3'b001; end
      else if (ex_redirect) begin e_en = 4'b1111; e_fl = 3'b110; end
      else if (lu)          begin e_en = 4'b0011; e_fl = 3'b010; end
      else                  begin e_en = 4'b1111; e_fl = 3'b000; end
      chk("enables", {pc_en, ifid_en, idex_en, exmem_en}, e_en);
      chk("flushes", {ifid_flush, idex_flush, memwb_flush}, e_fl);
      chk("fwdA", fwdA, e_a);
      chk("fwdB", fwdB, e_b);
      chk("fault", fault, m_faulted);
      chk("stall_cycles", stall_cycles, m_stalls % (1 << CW));
      if (rst) begin
        m_faulted = 0; m_busy = 0; m_len = 0; m_stalls = 0;
      end else begin
        if (e_en[3] == 1'b0) m_stalls++;
        if (!m_faulted) begin
          if (m_busy) begin
            if (mem_req && dmem_ready) begin
              m_busy = 0; m_len = 0;
            end else begin
              m_len++;
              if (m_len >= T + 1) m_faulted = 1;
            end
          end else if (mem_req && !dmem_ready) begin
            m_busy = 1; m_len = 1;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_useRs1 = 0; id_useRs2 = 0;
    ex_rd = 0; ex_memRead = 0; ex_regWrite = 0; ex_redirect = 0;
    ex_rs1 = 0; ex_rs2 = 0; mem_rd = 0; mem_regWrite = 0;
    mem_req = 0; dmem_ready = 0; wb_rd = 0; wb_regWrite = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cyc();
    rst = 0;
  endtask

  initial begin
    int fault_age;
    bit s_busy;
    idle();
    rst = 1;
    cyc();
    chk_en = 1;
    // Outputs are forced during reset even with forwarding hits present.
    ex_rs1 = 5; mem_regWrite = 1; mem_rd = 5; ex_redirect = 1;
    @(negedge clk);
    chk("rst_en", {pc_en, ifid_en, idex_en, exmem_en}, 4'b0000);
    chk("rst_flush", {ifid_flush, idex_flush, memwb_flush}, 3'b111);
    chk("rst_fwdA", fwdA, 2'b00);
    cyc();
    rst = 0; idle();

    ex_rs1 = 5; mem_regWrite = 1; mem_rd = 5; wb_regWrite = 1; wb_rd = 5;
    @(negedge clk);
    chk("fwd_mem_wins", fwdA, 2'b10);
    chk("stall_after_rst", stall_cycles, 0);
    cyc();
    mem_rd = 0;
    @(negedge clk);
    chk("fwd_wb", fwdA, 2'b01);
    cyc();
    wb_rd = 0;
    @(negedge clk);
    chk("fwd_x0", fwdA, 2'b00);
    cyc();

    idle();
    ex_memRead = 1; ex_regWrite = 1; ex_rd = 7; id_rs2 = 7; id_useRs2 = 1;
    @(negedge clk);
    chk("lu_pc_en", pc_en, 1'b0);
    chk("lu_idex_flush", idex_flush, 1'b1);
    chk("lu_idex_en", idex_en, 1'b1);
    cyc();
    idle();
    @(negedge clk);
    chk("lu_done_pc_en", pc_en, 1'b1);
    chk("lu_stall_cnt", stall_cycles, 1);
    cyc();

    ex_redirect = 1;
    @(negedge clk);
    chk("redir_flush", {ifid_flush, idex_flush, memwb_flush}, 3'b110);
    chk("redir_pc_en", pc_en, 1'b1);
    cyc();
    ex_memRead = 1; ex_rd = 7; id_rs2 = 7; id_useRs2 = 1;
    @(negedge clk);
    chk("redir_over_lu", {pc_en, ifid_flush, idex_flush}, 3'b111);
    cyc();

    do_reset();
    mem_req = 1; dmem_ready = 0; ex_redirect = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wait_en", {pc_en, ifid_en, idex_en, exmem_en}, 4'b0000);
      chk("wait_flush", {ifid_flush, idex_flush, memwb_flush}, 3'b001);
      cyc();
    end
    dmem_ready = 1;
    @(negedge clk);
    chk("wait_done_redir", {pc_en, ifid_flush, idex_flush, memwb_flush}, 4'b1110);
    cyc();
    idle();
    @(negedge clk);
    chk("wait_stall_cnt", stall_cycles, 3);
    cyc();

    do_reset();
    mem_req = 1; dmem_ready = 0;
    for (int i = 0; i < T + 1; i++) begin
      @(negedge clk);
      chk("pre_fault", {fault, pc_en}, 2'b00);
      cyc();
    end
    @(negedge clk);
    chk("fault_set", fault, 1'b1);
    chk("fault_stall_cnt", stall_cycles, T + 1);
    cyc();
    mem_req = 0;
    repeat (300) cyc();
    @(negedge clk);
    chk("fault_sticky", {fault, pc_en, memwb_flush}, 3'b101);
    cyc();
    rst = 1;
    @(negedge clk);
    chk("fault_rst_en", {pc_en, ifid_en, idex_en, exmem_en}, 4'b0000);
    chk("fault_rst_flush", {ifid_flush, idex_flush, memwb_flush}, 3'b111);
    cyc();
    rst = 0;
    @(negedge clk);
    chk("fault_cleared", {fault, pc_en}, 2'b01);
    chk("fault_cnt_cleared", stall_cycles, 0);
    cyc();

    mem_req = 1; dmem_ready = 0;
    cyc(); cyc();
    rst = 1;
    @(negedge clk);
    chk("midwait_rst", {pc_en, ifid_flush, memwb_flush}, 3'b011);
    cyc();
    rst = 0; idle(); dmem_ready = 1;
    @(negedge clk);
    chk("ready_no_req", pc_en, 1'b1);
    cyc();
    mem_req = 1; dmem_ready = 1;
    @(negedge clk);
    chk("ready_first", {pc_en, stall_cycles}, {1'b1, 8'd0});
    cyc();

    s_busy = 0;
    fault_age = 0;
    for (int n = 0; n < 3000; n++) begin
      fault_age = m_faulted ? fault_age + 1 : 0;
      rst = ($urandom_range(0, 149) == 0) || (fault_age > 12);
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_useRs1 = 1'($urandom); id_useRs2 = 1'($urandom);
      ex_rd = 5'($urandom_range(0, 3)); ex_memRead = ($urandom_range(0, 2) == 0);
      ex_regWrite = 1'($urandom); ex_redirect = ($urandom_range(0, 4) == 0);
      ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
      mem_rd = 5'($urandom_range(0, 3)); mem_regWrite = 1'($urandom);
      wb_rd = 5'($urandom_range(0, 3)); wb_regWrite = 1'($urandom);
      mem_req = s_busy ? 1'b1 : ($urandom_range(0, 3) == 0);
      dmem_ready = ($urandom_range(0, 2) == 0);
      if (rst) s_busy = 0;
      else if (mem_req) s_busy = !dmem_ready;
      cyc();
    end

    rst = 0; idle();
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
